// File: rtl/result_sram_writer.sv
// Streams a programmed number of packed result words into SRAM through a req/gnt
// write port. A small FIFO decouples capture from SRAM back-pressure.
module result_sram_writer #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              shift_out,
  input  logic [31:0]       to_sram,
  output logic              sram_req,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic              sram_gnt,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_cap_pend;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_cap_cnt;
  logic [ADDR_W-1:0] r_wptr;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_idx;
  logic [PTR_W-1:0]  r_wr_idx;
  logic [PTR_W:0]    r_count;
  logic              r_overflow;

  logic w_start_acc;
  logic w_push_ev;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_last_cap;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = !w_empty && sram_gnt;
  // The result register holds the new word one cycle after shift_out.
  assign w_push_ev  = (r_state == S_RUN) && r_cap_pend;
  assign w_push     = w_push_ev && (!w_full || w_pop);
  assign w_last_cap = w_push_ev && ((r_cap_cnt + CNT_W'(1)) == r_num);

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (num_words == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (w_last_cap) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty)    w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= S_IDLE;
      r_cap_pend <= 1'b0;
      r_num      <= '0;
      r_cap_cnt  <= '0;
      r_wptr     <= '0;
      r_rd_idx   <= '0;
      r_wr_idx   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cap_pend <= shift_out;
      if (w_start_acc) begin
        r_num      <= num_words;
        r_cap_cnt  <= '0;
        r_wptr     <= base_addr;
        r_overflow <= 1'b0;
      end else begin
        if (w_push_ev)           r_cap_cnt  <= r_cap_cnt + CNT_W'(1);
        if (w_push_ev && !w_push) r_overflow <= 1'b1;
        if (w_pop)               r_wptr     <= r_wptr + ADDR_W'(4);
      end
      if (w_push) r_wr_idx <= r_wr_idx + PTR_W'(1);
      if (w_pop)  r_rd_idx <= r_rd_idx + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_idx] <= to_sram;
  end

  // Request and data depend only on registered FIFO state, never on sram_gnt.
  assign sram_req   = !w_empty;
  assign sram_we    = sram_req;
  assign sram_be    = sram_req ? 4'hF : 4'h0;
  assign sram_addr  = r_wptr;
  assign sram_wdata = sram_req ? r_mem[r_rd_idx] : 32'h0;
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign overflow   = r_overflow;

endmodule

// File: doc/result_sram_writer.md
Name: result_sram_writer

Overview:
- Downstream consumer of the packed 32-bit result word (to_sram) from the result register.
- Writes a programmed number of consecutive result words into SRAM, starting at a base address, through a req/gnt write port.
- Observes shift_out so it knows when a new packed word will appear.
- Holds words in a small FIFO so SRAM back-pressure does not stall the datapath.

Parameters:
- ADDR_W, 32, SRAM byte-address width.
- CNT_W, 16, word-count width.
- FIFO_DEPTH, 4, buffer entries; must be a power of 2 and at least 2.

Ports:
- CLK  input  1  clock, rising edge.
- RESETn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a transfer.
- base_addr  input  ADDR_W  first byte address; sampled on start.
- num_words  input  CNT_W  number of words to write; sampled on start.
- shift_out  input  1  same strobe that loads the result register.
- to_sram  input  32  packed word {res_a,res_b} from the result register.
- sram_req  output  1  write request.
- sram_we  output  1  write enable; equals sram_req.
- sram_be  output  4  byte enables; 4'hF whenever sram_req=1, else 4'h0.
- sram_addr  output  ADDR_W  write byte address.
- sram_wdata  output  32  write data.
- sram_gnt  input  1  SRAM accepts the request this cycle.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- overflow  output  1  sticky; a word was dropped.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; FIFO empty; counters zero; all outputs 0, including sram_req.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE, start=1: latch base_addr and num_words; clear capture count, write pointer and overflow.
    - num_words=0: go to DONE.
    - Otherwise: go to RUN.
  - start in RUN or DRAIN: ignored.
- Capture:
  - cap_pend is a register loaded with shift_out every cycle.
  - In RUN, cap_pend=1 causes a push of to_sram. This is the cycle after shift_out, when the result register holds the new word.
  - Each push event increments the capture count, whether or not the word is stored.
  - When capture count reaches num_words, go to DRAIN. Later cap_pend events are ignored.
  - In IDLE, DRAIN and DONE, shift_out and cap_pend are ignored.
- FIFO push and pop:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set. overflow stays set until the next accepted start or reset.
- SRAM handshake:
  - sram_req = FIFO not empty.
  - sram_addr = write pointer; sram_wdata = FIFO head.
  - Both are stable while sram_req=1 and sram_gnt=0.
  - A transfer completes in a cycle where sram_req and sram_gnt are both 1. On completion: pop the FIFO, write pointer += 4 (wraps modulo 2^ADDR_W).
  - sram_gnt while sram_req=0 has no effect.
  - There is no combinational path from sram_gnt to sram_req, sram_addr or sram_wdata.
- DRAIN → DONE when the FIFO is empty. sram_req is therefore 0 in DONE.
- Latency:
  - shift_out at cycle t: the word is in the FIFO at t+2.
  - If the FIFO was empty and sram_gnt is held at 1, the SRAM write completes at t+2.
- done:
  - done=1 from entry to DONE until the next accepted start or reset.
  - busy and done are never both 1.
- Back-to-back shift_out every cycle is supported. With sram_gnt tied to 1, no word is ever dropped.

Test Plan:
1. base_addr=0x1000, num_words=3, three shift_out pulses with to_sram=0xAAAA0001/0xAAAA0002/0xAAAA0003, sram_gnt=1 → writes at 0x1000/0x1004/0x1008 with matching data, be=4'hF; done=1; overflow=0.
2. num_words=2, sram_gnt=0 for 10 cycles after the first request → addr and wdata hold stable; busy=1 throughout; both words are written after gnt rises; done=1.
3. FIFO_DEPTH=4, num_words=6, shift_out every cycle, sram_gnt=0 → words 5 and 6 dropped; overflow=1; gnt=1 then writes exactly 4 words at base..base+12; done=1.
4. num_words=0 start → DONE in the next cycle; sram_req is never asserted.
5. Assert RESETn low mid-transfer with sram_req=1 → sram_req, busy and done go to 0 immediately. After release, a new start with base_addr=0x2000 writes from 0x2000.
6. base_addr=0xFFFFFFFC, num_words=2 → addresses 0xFFFFFFFC then 0x00000000. A start pulse during RUN is ignored: the count and address are unchanged.
